// File: rtl/ecc_serial_tx.sv
// Serializes a P/a operand frame (mode, P, ax, ay, prime) or a Pb frame (Pbx, Pby) MSB first.
// Optional operand range check is compiled in with `define ECC_TX_RANGE_CHECK_EN.
module ecc_serial_tx #(
  parameter int unsigned MAX_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pa_req,
  output logic                pa_ready,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] P,
  input  logic [MAX_BITS-1:0] ax,
  input  logic [MAX_BITS-1:0] ay,
  input  logic [MAX_BITS-1:0] prime,
  input  logic                pb_req,
  output logic                pb_ready,
  input  logic [MAX_BITS-1:0] Pbx,
  input  logic [MAX_BITS-1:0] Pby,
  output logic                o_p_a_valid,
  output logic                o_pb_valid,
  output logic                o_mode,
  output logic                o_P,
  output logic                o_ax,
  output logic                o_ay,
  output logic                o_prime,
  output logic                o_Pbx,
  output logic                o_Pby,
  output logic                busy,
  output logic                err
);

  typedef enum logic [2:0] {
    StIdle, StPaStart, StModeOut, StPaData, StPbStart, StPbData
  } state_e;

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [1:0]          mode_q, pb_mode_q;
  logic                armed_q;
  logic [MAX_BITS-1:0] p_q, ax_q, ay_q, prime_q, pbx_q, pby_q;
  logic                pa_acc, pb_acc, pa_bad, pb_bad, pa_load, pb_load, arm_set;
  logic [7:0]          bit_idx;
  logic                pa_data, pb_data;

  function automatic logic [8:0] last_idx(input logic [1:0] m);
    logic [8:0] r;
    case (m)
      2'b00:   r = 9'd31;
      2'b01:   r = 9'd63;
      2'b10:   r = 9'd127;
      default: r = 9'd255;
    endcase
    return r;
  endfunction

`ifdef ECC_TX_RANGE_CHECK_EN
  function automatic logic above_n(input logic [MAX_BITS-1:0] v, input logic [1:0] m);
    logic r;
    case (m)
      2'b00:   r = |v[255:32];
      2'b01:   r = |v[255:64];
      2'b10:   r = |v[255:128];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign pa_bad = above_n(P, mode) | above_n(ax, mode) | above_n(ay, mode) |
                  above_n(prime, mode);
  // Pb width follows the mode of the last completed PA frame.
  assign pb_bad = above_n(Pbx, pb_mode_q) | above_n(Pby, pb_mode_q);
  assign err    = (pa_acc & pa_bad) | (pb_acc & pb_bad);
`else
  assign pa_bad = 1'b0;
  assign pb_bad = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pa_acc  = 1'b0;
    pb_acc  = 1'b0;
    arm_set = 1'b0;
    case (state_q)
      StIdle: begin
        // Gate on rst so ready stays low while reset is held.
        if (!rst) begin
          if (pa_req) begin
            pa_acc = 1'b1;
            if (!pa_bad) state_d = StPaStart;
          end else if (pb_req && armed_q) begin
            pb_acc = 1'b1;
            if (!pb_bad) state_d = StPbStart;
          end
        end
      end
      StPaStart: begin
        state_d = StModeOut;
        cnt_d   = 9'd1;
      end
      StModeOut: begin
        if (cnt_q == 9'd0) begin
          state_d = StPaData;
          cnt_d   = last_idx(mode_q);
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      StPaData: begin
        if (cnt_q == 9'd0) begin
          state_d = StIdle;
          arm_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      StPbStart: begin
        state_d = StPbData;
        cnt_d   = last_idx(pb_mode_q);
      end
      StPbData: begin
        if (cnt_q == 9'd0) state_d = StIdle;
        else               cnt_d = cnt_q - 9'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pa_load = pa_acc & ~pa_bad;
  assign pb_load = pb_acc & ~pb_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 9'd0;
      armed_q   <= 1'b0;
      pb_mode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (arm_set) begin
        armed_q   <= 1'b1;
        pb_mode_q <= mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'b00;
      p_q     <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      prime_q <= '0;
      pbx_q   <= '0;
      pby_q   <= '0;
    end else begin
      if (pa_load) begin
        mode_q  <= mode;
        p_q     <= P;
        ax_q    <= ax;
        ay_q    <= ay;
        prime_q <= prime;
      end
      if (pb_load) begin
        pbx_q <= Pbx;
        pby_q <= Pby;
      end
    end
  end

  assign bit_idx     = cnt_q[7:0];
  assign pa_data     = (state_q == StPaData);
  assign pb_data     = (state_q == StPbData);

  assign pa_ready    = pa_acc;
  assign pb_ready    = pb_acc;
  assign o_p_a_valid = (state_q == StPaStart);
  assign o_pb_valid  = (state_q == StPbStart);
  // Counter 1 then 0 selects mode[1] then mode[0].
  assign o_mode      = (state_q == StModeOut) & mode_q[cnt_q[0]];
  assign o_P         = pa_data & p_q[bit_idx];
  assign o_ax        = pa_data & ax_q[bit_idx];
  assign o_ay        = pa_data & ay_q[bit_idx];
  assign o_prime     = pa_data & prime_q[bit_idx];
  assign o_Pbx       = pb_data & pbx_q[bit_idx];
  assign o_Pby       = pb_data & pby_q[bit_idx];
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ecc_serial_tx.sv
// Bench for ecc_serial_tx: frame-level reference model checked every cycle, plus literal pins.
module tb_ecc_serial_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pa_req, pb_req;
  logic [1:0]   mode;
  logic [255:0] P, ax, ay, prime, Pbx, Pby;
  logic         pa_ready, pb_ready, o_p_a_valid, o_pb_valid, o_mode;
  logic         o_P, o_ax, o_ay, o_prime, o_Pbx, o_Pby, busy, err;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  ecc_serial_tx dut (
    .clk(clk), .rst(rst),
    .pa_req(pa_req), .pa_ready(pa_ready), .mode(mode),
    .P(P), .ax(ax), .ay(ay), .prime(prime),
    .pb_req(pb_req), .pb_ready(pb_ready), .Pbx(Pbx), .Pby(Pby),
    .o_p_a_valid(o_p_a_valid), .o_pb_valid(o_pb_valid), .o_mode(o_mode),
    .o_P(o_P), .o_ax(o_ax), .o_ay(o_ay), .o_prime(o_prime),
    .o_Pbx(o_Pbx), .o_Pby(o_Pby), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg_at(input int k);
    while (cyc < k) tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit above(input logic [255:0] v, input int n);
    if (n >= 256) return 1'b0;
    return (v >> n) != 256'd0;
  endfunction

  // Reference model: one active frame record; outputs derived from offset into the frame.
  bit           have_f, f_pa, armed;
  int           f_t, f_n, f_end, armed_n, d;
  logic [1:0]   f_mode;
  logic [255:0] f_p, f_ax, f_ay, f_pr, f_bx, f_by;
  logic e_par, e_pbr, e_err, e_pav, e_pbv, e_mode, e_p, e_ax, e_ay, e_pr, e_bx, e_by, e_busy;
  bit   pa_bad, pb_bad;

  always @(negedge clk) begin
    {e_par, e_pbr, e_err, e_pav, e_pbv, e_mode, e_p, e_ax, e_ay, e_pr, e_bx, e_by, e_busy} = '0;
    pa_bad = 1'b0;
    pb_bad = 1'b0;
    if (rst) begin
      have_f  = 1'b0;
      armed   = 1'b0;
      armed_n = 0;
    end else begin
      if (have_f && cyc >= f_end) begin
        if (f_pa) begin
          armed   = 1'b1;
          armed_n = f_n;
        end
        have_f = 1'b0;
      end
      e_par = !have_f && pa_req;
      e_pbr = !have_f && !pa_req && pb_req && armed;
`ifdef ECC_TX_RANGE_CHECK_EN
      pa_bad = above(P, 32 << mode) || above(ax, 32 << mode) || above(ay, 32 << mode) ||
               above(prime, 32 << mode);
      pb_bad = above(Pbx, armed_n) || above(Pby, armed_n);
      e_err  = (e_par && pa_bad) || (e_pbr && pb_bad);
`endif
      if (have_f) begin
        d      = cyc - f_t;
        e_busy = 1'b1;
        if (f_pa) begin
          e_pav  = (d == 1);
          e_mode = (d == 2) ? f_mode[1] : (d == 3) ? f_mode[0] : 1'b0;
          if (d >= 4 && d <= 3 + f_n) begin
            e_p  = f_p[f_n + 3 - d];
            e_ax = f_ax[f_n + 3 - d];
            e_ay = f_ay[f_n + 3 - d];
            e_pr = f_pr[f_n + 3 - d];
          end
        end else begin
          e_pbv = (d == 1);
          if (d >= 2 && d <= 1 + f_n) begin
            e_bx = f_bx[f_n + 1 - d];
            e_by = f_by[f_n + 1 - d];
          end
        end
      end
    end
    chk("pa_ready", pa_ready, e_par);
    chk("pb_ready", pb_ready, e_pbr);
    chk("err", err, e_err);
    chk("o_p_a_valid", o_p_a_valid, e_pav);
    chk("o_pb_valid", o_pb_valid, e_pbv);
    chk("o_mode", o_mode, e_mode);
    chk("o_P", o_P, e_p);
    chk("o_ax", o_ax, e_ax);
    chk("o_ay", o_ay, e_ay);
    chk("o_prime", o_prime, e_pr);
    chk("o_Pbx", o_Pbx, e_bx);
    chk("o_Pby", o_Pby, e_by);
    chk("busy", busy, e_busy);
    if (!rst && e_par && !pa_bad) begin
      have_f = 1'b1; f_pa = 1'b1; f_t = cyc; f_mode = mode; f_n = 32 << mode;
      f_end = cyc + 4 + f_n;
      f_p = P; f_ax = ax; f_ay = ay; f_pr = prime;
    end else if (!rst && e_pbr && !pb_bad) begin
      have_f = 1'b1; f_pa = 1'b0; f_t = cyc; f_n = armed_n; f_end = cyc + 2 + f_n;
      f_bx = Pbx; f_by = Pby;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int t, c;

  initial begin
    pa_req = 0; pb_req = 0; mode = 0;
    P = '0; ax = '0; ay = '0; prime = '0; Pbx = '0; Pby = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pa_ready", pa_ready, 1'b0);
    tick();
    rst = 0;

    // Pb before any completed PA frame is never accepted.
    pb_req = 1;
    repeat (100) tick();
    @(negedge clk);
    chk("unarmed_pb_ready", pb_ready, 1'b0);
    chk("unarmed_busy", busy, 1'b0);
    tick();
    pb_req = 0;

    // 32-bit frame with pinned bit values.
    tick();
    mode = 2'b00; P = 256'h8000_0001; ax = 256'h1; ay = 256'hFFFF_FFFF;
    prime = 256'hFFFF_FFFB; pa_req = 1; t = cyc;
    tick();
    pa_req = 0;
    neg_at(t + 1);  chk("m32_valid", o_p_a_valid, 1'b1);
    neg_at(t + 2);  chk("m32_mode_hi", o_mode, 1'b0);
    neg_at(t + 4);  chk("m32_p_msb", o_P, 1'b1);
    for (int k = 5; k <= 34; k++) begin
      neg_at(t + k); chk("m32_p_mid", o_P, 1'b0);
    end
    neg_at(t + 35); chk("m32_p_lsb", o_P, 1'b1);
    chk("m32_prime_b0", o_prime, 1'b1);
    chk("m32_busy_last", busy, 1'b1);
    neg_at(t + 36); chk("m32_busy_fall", busy, 1'b0);

    // Operands change right after accept; latched values must be sent.
    tick();
    mode = 2'b01; P = 256'hC000_0000_0000_0003; ax = rand256(); ay = rand256();
    prime = rand256(); pa_req = 1; t = cyc;
    tick();
    pa_req = 0; mode = 2'b11; P = '0; ax = rand256(); ay = rand256(); prime = rand256();
    neg_at(t + 2);  chk("m64_mode_hi", o_mode, 1'b0);
    neg_at(t + 3);  chk("m64_mode_lo", o_mode, 1'b1);
    neg_at(t + 4);  chk("m64_p63", o_P, 1'b1);
    neg_at(t + 5);  chk("m64_p62", o_P, 1'b1);
    neg_at(t + 6);  chk("m64_p61", o_P, 1'b0);
    neg_at(t + 67); chk("m64_p0", o_P, 1'b1);
    neg_at(t + 68); chk("m64_busy_fall", busy, 1'b0);

    // Asynchronous reset mid-frame clears everything and disarms Pb.
    tick();
    mode = 2'b01; P = rand256(); ax = rand256(); ay = rand256(); prime = rand256();
    P[63] = 1'b1; pa_req = 1; t = cyc;
    tick();
    pa_req = 0;
    while (cyc < t + 14) tick();
    #1 rst = 1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_o_P", o_P | o_ax | o_ay | o_prime, 1'b0);
    chk("arst_valid", o_p_a_valid | o_pb_valid | o_mode, 1'b0);
    tick();
    tick();
    rst = 0;
    pb_req = 1;
    repeat (20) tick();
    @(negedge clk);
    chk("arst_pb_ready", pb_ready, 1'b0);
    tick();
    pb_req = 0;

    // 256-bit frame, then simultaneous PA/PB requests.
    tick();
    mode = 2'b11; P = rand256(); ax = rand256(); ay = rand256(); prime = rand256();
    pa_req = 1; t = cyc;
    tick();
    pa_req = 0;
    while (cyc < t + 262) tick();
    P = rand256(); ax = rand256(); ay = rand256(); prime = rand256();
    Pbx = 256'hA5; Pbx[255] = 1'b1; Pby = 256'hA5;
    pa_req = 1; pb_req = 1; c = cyc;
    @(negedge clk);
    chk("both_pa_ready", pa_ready, 1'b1);
    chk("both_pb_ready", pb_ready, 1'b0);
    tick();
    pa_req = 0;
    neg_at(c + 259); chk("pb_wait", pb_ready, 1'b0);
    neg_at(c + 260); chk("pb_accept", pb_ready, 1'b1);
    tick();
    pb_req = 0; Pbx = '0; Pby = '0;
    @(negedge clk);  chk("pb_valid", o_pb_valid, 1'b1);
    neg_at(c + 262); chk("pbx_b255", o_Pbx, 1'b1);
    neg_at(c + 509); chk("pbx_b8", o_Pbx, 1'b0);
    neg_at(c + 510); chk("pbx_b7", o_Pbx, 1'b1);
    neg_at(c + 516); chk("pbx_b1", o_Pbx, 1'b0);
    neg_at(c + 517); chk("pbx_b0", o_Pbx, 1'b1);
    chk("pby_b0", o_Pby, 1'b1);
    neg_at(c + 518); chk("pb_busy_fall", busy, 1'b0);

    // Out-of-range upper bit in a 32-bit request.
    tick();
    mode = 2'b00; P = 256'h1_0000_0000; ax = 256'h0; ay = 256'h0; prime = 256'h0;
    pa_req = 1; t = cyc;
    @(negedge clk);
    chk("rng_pa_ready", pa_ready, 1'b1);
`ifdef ECC_TX_RANGE_CHECK_EN
    chk("rng_err", err, 1'b1);
`else
    chk("rng_err", err, 1'b0);
`endif
    tick();
    pa_req = 0;
    @(negedge clk);
`ifdef ECC_TX_RANGE_CHECK_EN
    chk("rng_no_valid", o_p_a_valid, 1'b0);
`else
    chk("rng_valid", o_p_a_valid, 1'b1);
`endif
    neg_at(t + 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
